// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder -- parameterised pipelined carry-lookahead adder.
//
// Computes {cout,s} = a + b + cin with one result per enabled cycle and a
// latency of exactly STAGES enabled clock edges. The WIDTH/BLOCK lookahead
// groups are spread over STAGES as evenly as possible, LSB groups first.
// Each stage resolves its groups from the carry registered by the stage
// before it. The unprocessed upper operand bits and the finished lower sum
// bits travel along in the stage registers.
//
// Parameters:
//   WIDTH  operand/sum width; must be a multiple of BLOCK
//   BLOCK  bits per lookahead group
//   STAGES pipeline depth, 1 .. WIDTH/BLOCK
//
// Ports:
//   clk        clock, posedge
//   rst        synchronous active-high reset; overrides en
//   en         pipeline advance; 0 freezes every register
//   in_valid   a/b/cin hold an operation this cycle
//   sub        (CLA_PIPE_SUB_EN only) 1 = a - b - cin (cin acts as borrow-in)
//   a, b, cin  operands and carry-in
//   out_valid  s/cout/ovf hold a result
//   s, cout    sum and carry out of the MSB
//   ovf        signed overflow (carry into MSB ^ carry out of MSB)
//
// Optional feature: define CLA_PIPE_SUB_EN to add the sub input port.

module cla_pipe_group #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             ci,
    output logic [BLOCK-1:0] s,
    output logic             gg,
    output logic             gp
);
    logic [BLOCK-1:0] g, p, c;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate/propagate depends only on the operands, so the
    // stage-level carry chain never waits on this group's carry-in.
    always_comb begin
        gg = 1'b0;
        gp = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            gg = g[i] | (p[i] & gg);
            gp = gp & p[i];
        end
    end

    always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK - 1; i++)
            c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign s = p ^ c;
endmodule

module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int NG = (BLOCK > 0) ? WIDTH / BLOCK : 1;

    if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a positive multiple of BLOCK");
    end
    if (STAGES < 1 || STAGES > NG) begin : g_bad_stages
        $error("cla_pipe_adder: STAGES must be in 1..WIDTH/BLOCK");
    end

    // a/b are the (possibly inverted) operands, s the sum built so far,
    // c the carry into the next unprocessed group, cm the carry into the MSB.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             cm;
    } stg_t;

    stg_t [STAGES-1:0] d, q;
    stg_t              in_stg;
    logic [STAGES-1:0] vld_pipe;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;

`ifdef CLA_PIPE_SUB_EN
    // a - b - cin == a + ~b + ~cin; the adder itself is unchanged.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    always_comb begin
        in_stg    = '0;
        in_stg.a  = a;
        in_stg.b  = b_eff;
        in_stg.c  = cin_eff;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int GS  = k * NG / STAGES;
        localparam int GE  = (k + 1) * NG / STAGES;
        localparam int NGS = GE - GS;

        stg_t                        src, nxt;
        logic [NGS:0]                cc;
        logic [NGS-1:0]              gg, gp;
        logic [NGS-1:0][BLOCK-1:0]   gs;

        if (k == 0) begin : g_src_in
            assign src = in_stg;
        end else begin : g_src_reg
            assign src = q[k-1];
        end

        for (genvar g = 0; g < NGS; g++) begin : g_grp
            cla_pipe_group #(.BLOCK(BLOCK)) u_grp (
                .a  (src.a[(GS+g)*BLOCK +: BLOCK]),
                .b  (src.b[(GS+g)*BLOCK +: BLOCK]),
                .ci (cc[g]),
                .s  (gs[g]),
                .gg (gg[g]),
                .gp (gp[g])
            );
        end

        // Group-level lookahead chain across this stage's groups.
        always_comb begin
            cc    = '0;
            cc[0] = src.c;
            for (int g = 0; g < NGS; g++)
                cc[g+1] = gg[g] | (gp[g] & cc[g]);
        end

        always_comb begin
            nxt = src;
            for (int g = 0; g < NGS; g++)
                nxt.s[(GS+g)*BLOCK +: BLOCK] = gs[g];
            nxt.c = cc[NGS];
            // Carry into the MSB recovered from the MSB sum bit.
            if (GE == NG)
                nxt.cm = nxt.s[WIDTH-1] ^ src.a[WIDTH-1] ^ src.b[WIDTH-1];
        end

        assign d[k] = nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= '0;
            vld_pipe <= '0;
        end else if (en) begin
            q           <= d;
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < STAGES; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign s         = q[STAGES-1].s;
    assign cout      = q[STAGES-1].c;
    assign ovf       = q[STAGES-1].c ^ q[STAGES-1].cm;

    // Operand copies in the last register and constant fields of the input
    // record are intentionally left unread.
    logic unused_ok;
    assign unused_ok = ^{q, in_stg};
endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
    localparam int W      = 16;
    localparam int STAGES = 2;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, cin;
    logic [W-1:0] a, b;
    logic         out_valid, cout, ovf;
    logic [W-1:0] s;
`ifdef CLA_PIPE_SUB_EN
    logic         sub;
`endif

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
`ifdef CLA_PIPE_SUB_EN
        .sub       (sub),
`endif
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic         iv;
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] es;
        logic         ec, eo;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c, o;
        int           launch;
    } exp_t;

    exp_t sbq[$];
    exp_t mx;
    vec_t tbl[$];
    int   ntot = 0, npass = 0;
    int   ecnt = 0;
    bit   fresh = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] x, y, input logic ci, sb);
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   sum;
        exp_t         r;
        yy     = sb ? ~y : y;
        cc     = sb ? ~ci : ci;
        sum    = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        r.s    = sum[W-1:0];
        r.c    = sum[W];
        r.o    = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
        r.launch = 0;
        return r;
    endfunction

    // One clock edge; the expected result is queued when the DUT samples it.
    task automatic step(input logic e, iv, input logic [W-1:0] aa, bb, input logic ci, sb,
                        input logic [W-1:0] es, input logic ec, eo);
        exp_t x;
        en = e; in_valid = iv; a = aa; b = bb; cin = ci;
`ifdef CLA_PIPE_SUB_EN
        sub = sb;
`endif
        @(posedge clk);
        if (e && !rst) begin
            ecnt++;
            fresh = 1'b1;
            if (iv) begin
                x.s = es; x.c = ec; x.o = eo; x.launch = ecnt;
                sbq.push_back(x);
            end
        end
        #1;
    endtask

    // Scoreboard: pop one expected result per new valid output slot.
    always @(negedge clk) begin
        if (fresh) begin
            fresh = 1'b0;
            if (out_valid === 1'b1) begin
                if (sbq.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else begin
                    mx = sbq.pop_front();
                    chk("sum", 32'(s), 32'(mx.s));
                    chk("cout", 32'(cout), 32'(mx.c));
                    chk("ovf", 32'(ovf), 32'(mx.o));
                    chk("latency", 32'(ecnt), 32'(mx.launch + STAGES - 1));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t r;
        logic [W-1:0] ra, rb;
        logic rc, rs, re, rv;

        // Reset with en/in_valid high: reset must win.
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; a = '1; b = '1; cin = 1'b1;
`ifdef CLA_PIPE_SUB_EN
        sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0; in_valid = 1'b0;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_s", 32'(s), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);

        //                 iv    a         b         cin   sub   s         c     o
        tbl.push_back('{1'b1, 16'h0003, 16'h0003, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
`ifdef CLA_PIPE_SUB_EN
        tbl.push_back('{1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0});
`endif
        foreach (tbl[i])
            step(1'b1, tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                 tbl[i].es, tbl[i].ec, tbl[i].eo);

        // Random stream with random stalls and bubbles.
        repeat (80) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            re = ($urandom_range(0, 5) != 0);
            rv = ($urandom_range(0, 3) != 0);
`ifdef CLA_PIPE_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            r = model(ra, rb, rc, rs);
            step(re, rv, ra, rb, rc, rs, r.s, r.c, r.o);
        end
        repeat (STAGES + 1) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("drain_queue_empty", 32'(sbq.size()), 32'd0);

        // Stall mid-flight: output keeps showing the preceding result.
        step(1'b1, 1'b1, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_s", 32'(s), 32'h1010);
        end
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("stall_result_s", 32'(s), 32'h2345);
        chk("stall_result_valid", 32'(out_valid), 32'd1);

        // Reset with operations in flight: they must never emerge.
        step(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 16'h7777, 1'b0, 1'b0);
        rst = 1'b1; en = 1'b1; in_valid = 1'b1; a = 16'h5555; b = 16'h5555;
        @(posedge clk);
        sbq.delete();
        fresh = 1'b0;
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        repeat (2 * STAGES) begin
            step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
            chk("post_reset_no_valid", 32'(out_valid), 32'd0);
        end

        // One more op after reset to show the pipe still works.
        step(1'b1, 1'b1, 16'h0003, 16'h0003, 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0);
        repeat (STAGES + 1) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("final_queue_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder; the next generation of the 16-bit clocked CLA.
- Generalised in operand width, lookahead group size and pipeline depth.
- Adds a valid qualifier, pipeline enable (stall), signed-overflow flag and synchronous reset.
- Sits in the ALU datapath; one result per cycle at full throughput.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK
BLOCK, 4, bits per lookahead group (group generate/propagate unit)
STAGES, 2, pipeline register stages (latency in cycles); 1 <= STAGES <= WIDTH/BLOCK

Ports:
clk  input  1  clock; all registers update on posedge
rst  input  1  synchronous active-high reset
en  input  1  pipeline advance enable; 0 freezes every stage
in_valid  input  1  a/b/cin carry a valid operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
out_valid  output  1  s/cout/ovf hold a valid result
s  output  WIDTH  sum
cout  output  1  carry out of MSB
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset: on posedge clk with rst=1, all stage registers cleared; out_valid=0, s=0, cout=0, ovf=0 on the following cycle. rst overrides en. Operations in flight at reset are discarded, never emitted.
- Arithmetic: {cout,s} = a + b + cin, modulo 2^(WIDTH+1). No sign extension.
- Lookahead: per-bit g=a&b, p=a^b. Group G/P computed per BLOCK. Carries between groups use lookahead (group-level), not ripple across all bits.
- Pipelining: the WIDTH/BLOCK groups are partitioned over STAGES as evenly as possible; LSB groups come first.
  - Stage k resolves its groups using the carry registered by stage k-1.
  - Unprocessed upper operand bits and completed lower sum bits travel with the operation in stage registers.
- Latency: exactly STAGES enabled clock edges from sampling in_valid=1 to out_valid=1 with that result.
- Throughput: one operation per enabled cycle; back-to-back operations never interfere.
- in_valid=0 inserts a bubble: out_valid=0 for that slot STAGES cycles later. s/cout/ovf outputs in bubble slots are don't-care for the bench.
- en=0: no register changes, including valid bits; outputs hold. Inputs presented while en=0 are ignored.
- en=1 with in_valid=1: inputs sampled at that edge.
- Overflow: ovf is asserted only for the signed case. Example: 0x7FFF+0x0001 gives ovf=1, cout=0.
- Elaboration: STAGES or WIDTH out of range is an error; stop with $error at elaboration.

Optional Feature:
Macro: CLA_PIPE_SUB_EN
- Defined:
  - Extra input port sub (1 bit), sampled and pipelined together with a/b.
  - sub=1: result = a + ~b + ~cin, i.e. s = a - b - cin. cin acts as borrow-in; cout = NOT borrow-out; ovf uses signed-subtract semantics (same carry XOR rule on the inverted operand).
  - sub=0: plain add.
- Not defined: no sub port; adder only. Latency and all other behaviour identical in both builds.

Test Plan:
- Reset then en=1, in_valid=1, a=0x0003, b=0x0003, cin=1 -> after STAGES cycles: out_valid=1, s=0x0007, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1.
- Back-to-back stream on consecutive cycles: (1,2,0), (0x00FF,0x0001,0), bubble, (0x8000,0x8000,0) -> results 0x0003; 0x0100; out_valid=0; s=0x0000 with cout=1, ovf=1, all in order at one per cycle.
- Stall: launch 0x1234+0x1111; hold en=0 for 3 cycles mid-flight -> outputs frozen during stall; result 0x2345 appears STAGES enabled edges after launch.
- Reset mid-operation: two ops in flight, rst=1 for 1 cycle -> out_valid=0, s=0; in-flight results never appear.
- CLA_PIPE_SUB_EN build: sub=1, a=5, b=3, cin=0 -> s=0x0002, cout=1; sub=1, a=3, b=5, cin=0 -> s=0xFFFE, cout=0; sub=1, a=0x8000, b=1 -> s=0x7FFF, ovf=1.
